// File: rtl/align_accum_if.sv
// ============================================================================
// Module      : align_accum_if
// Description : Bundles the beat-in / group-result-out handshake of the
//               align_accum block.
//                 in_valid/in_ready/align_pp/in_last/flush : upstream beats
//                 out_valid/out_ready/acc_sum/out_count/out_forced : results
//               Modport "master" is the environment side, "slave" the block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface align_accum_if #(
  parameter int PP_W      = 15,
  parameter int MAX_TERMS = 16
) ();
  localparam int SUM_W  = PP_W + $clog2(MAX_TERMS);
  localparam int OCNT_W = $clog2(MAX_TERMS) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [PP_W-1:0]   align_pp;
  logic              in_last;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [SUM_W-1:0]  acc_sum;
  logic [OCNT_W-1:0] out_count;
  logic              out_forced;

  modport master (
    output in_valid, align_pp, in_last, flush, out_ready,
    input  in_ready, out_valid, acc_sum, out_count, out_forced
  );

  modport slave (
    input  in_valid, align_pp, in_last, flush, out_ready,
    output in_ready, out_valid, acc_sum, out_count, out_forced
  );
endinterface

`default_nettype wire

// File: rtl/align_accum.sv
// ============================================================================
// Module      : align_accum
// Description : Sums groups of signed aligned partial products. A group is
//               closed by a beat with in_last=1 or when it reaches MAX_TERMS
//               terms; the result is presented one cycle later in a single
//               output register with a valid/ready handshake. flush drops
//               the partially accumulated group without touching the result.
// Ports       : clk    - clock, all state on rising edge
//               rst    - synchronous active-high reset
//               io_bus - align_accum_if.slave (beat input, result output)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module align_accum #(
  parameter int PP_W      = 15,
  parameter int MAX_TERMS = 16,
  parameter int SUM_W     = PP_W + $clog2(MAX_TERMS)
) (
  input  wire logic    clk,
  input  wire logic    rst,
  align_accum_if.slave io_bus
);

  // Running counter only needs 0..MAX_TERMS-1; the reported count reaches
  // MAX_TERMS and therefore needs one extra bit.
  localparam int CNT_W  = $clog2(MAX_TERMS);
  localparam int OCNT_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(MAX_TERMS - 1);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SUM_W-1:0]    r_acc;
  logic [SUM_W-1:0]    w_acc_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;

  logic                r_out_valid;
  logic                w_out_valid_nxt;
  logic [SUM_W-1:0]    r_acc_sum;
  logic [SUM_W-1:0]    w_acc_sum_nxt;
  logic [OCNT_W-1:0]   r_out_count;
  logic [OCNT_W-1:0]   w_out_count_nxt;
  logic                r_out_forced;
  logic                w_out_forced_nxt;

  logic                w_in_ready;
  logic                w_accept;
  logic                w_close;
  logic [SUM_W-1:0]    w_ext;
  logic [SUM_W-1:0]    w_base;
  logic [SUM_W-1:0]    w_sum;

  // A beat may enter whenever the output register is free or being drained
  // this very cycle, which gives one closed group per cycle.
  assign w_in_ready = ~io_bus.flush & (~r_out_valid | io_bus.out_ready);
  assign w_accept   = io_bus.in_valid & w_in_ready;

  assign w_ext  = {{(SUM_W-PP_W){io_bus.align_pp[PP_W-1]}}, io_bus.align_pp};
  // In EMPTY the group starts from zero regardless of the accumulator value.
  assign w_base = (r_state == S_EMPTY) ? '0 : r_acc;
  assign w_sum  = w_base + w_ext;

  assign w_close = w_accept & (io_bus.in_last | (r_cnt == c_CNT_LAST));

  always_comb begin
    w_state_nxt      = r_state;
    w_acc_nxt        = r_acc;
    w_cnt_nxt        = r_cnt;
    w_acc_sum_nxt    = r_acc_sum;
    w_out_count_nxt  = r_out_count;
    w_out_forced_nxt = r_out_forced;
    w_out_valid_nxt  = r_out_valid & ~io_bus.out_ready;

    if (io_bus.flush) begin
      w_state_nxt = S_EMPTY;
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
    end else if (w_close) begin
      w_state_nxt      = S_EMPTY;
      w_acc_nxt        = '0;
      w_cnt_nxt        = '0;
      w_acc_sum_nxt    = w_sum;
      w_out_count_nxt  = {1'b0, r_cnt} + OCNT_W'(1);
      w_out_forced_nxt = ~io_bus.in_last;
      w_out_valid_nxt  = 1'b1;
    end else if (w_accept) begin
      w_state_nxt = S_ACCUM;
      w_acc_nxt   = w_sum;
      w_cnt_nxt   = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_EMPTY;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_out_valid  <= 1'b0;
      r_acc_sum    <= '0;
      r_out_count  <= '0;
      r_out_forced <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_acc        <= w_acc_nxt;
      r_cnt        <= w_cnt_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_acc_sum    <= w_acc_sum_nxt;
      r_out_count  <= w_out_count_nxt;
      r_out_forced <= w_out_forced_nxt;
    end
  end

  assign io_bus.in_ready   = w_in_ready;
  assign io_bus.out_valid  = r_out_valid;
  assign io_bus.acc_sum    = r_acc_sum;
  assign io_bus.out_count  = r_out_count;
  assign io_bus.out_forced = r_out_forced;

endmodule

`default_nettype wire

// File: tb/tb_align_accum.sv
// ============================================================================
// Module      : tb_align_accum
// Description : Directed self-checking bench for align_accum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_align_accum;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  align_accum_if #(.PP_W(15), .MAX_TERMS(16)) bus_if ();

  align_accum #(.PP_W(15), .MAX_TERMS(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge, then advance to the next
  // falling edge so registered outputs of that rising edge are visible.
  task automatic step(input logic v, input logic [14:0] pp, input logic last,
                      input logic fl, input logic rdy);
    bus_if.in_valid  = v;
    bus_if.align_pp  = pp;
    bus_if.in_last   = last;
    bus_if.flush     = fl;
    bus_if.out_ready = rdy;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.in_valid = 1'b0; bus_if.align_pp = '0; bus_if.in_last = 1'b0;
    bus_if.flush = 1'b0; bus_if.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (bus_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0h want 0", bus_if.out_valid); end
    n_checks++; if (bus_if.acc_sum !== 19'd0) begin n_fail++; $display("FAIL reset_acc_sum: got %0h want 0", bus_if.acc_sum); end
    n_checks++; if (bus_if.out_count !== 5'd0) begin n_fail++; $display("FAIL reset_out_count: got %0d want 0", bus_if.out_count); end
    n_checks++; if (bus_if.out_forced !== 1'b0) begin n_fail++; $display("FAIL reset_out_forced: got %0h want 0", bus_if.out_forced); end
    n_checks++; if (bus_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0h want 1", bus_if.in_ready); end
    @(negedge clk);
  endtask

  task automatic test_basic_group();
    step(1'b1, 15'h3800, 1'b0, 1'b0, 1'b1);
    step(1'b1, 15'h0100, 1'b0, 1'b0, 1'b1);
    step(1'b1, 15'h7F00, 1'b1, 1'b0, 1'b1);
    n_checks++; if (bus_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0h want 1", bus_if.out_valid); end
    n_checks++; if (bus_if.acc_sum !== 19'd14336) begin n_fail++; $display("FAIL basic_sum: got %0d want 14336", bus_if.acc_sum); end
    n_checks++; if (bus_if.out_count !== 5'd3) begin n_fail++; $display("FAIL basic_count: got %0d want 3", bus_if.out_count); end
    n_checks++; if (bus_if.out_forced !== 1'b0) begin n_fail++; $display("FAIL basic_forced: got %0h want 0", bus_if.out_forced); end
    step(1'b0, 15'h0000, 1'b0, 1'b0, 1'b1);
    n_checks++; if (bus_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %0h want 0", bus_if.out_valid); end
  endtask

  task automatic test_backpressure();
    step(1'b1, 15'h4000, 1'b1, 1'b0, 1'b0);
    n_checks++; if (bus_if.acc_sum !== 19'h7C000) begin n_fail++; $display("FAIL bp_sum: got %0h want 7c000", bus_if.acc_sum); end
    n_checks++; if (bus_if.out_count !== 5'd1) begin n_fail++; $display("FAIL bp_count: got %0d want 1", bus_if.out_count); end
    for (int i = 0; i < 5; i++) begin
      // A beat is offered the whole time; it must not be taken.
      bus_if.in_valid = 1'b1; bus_if.align_pp = 15'h0001; bus_if.in_last = 1'b1;
      bus_if.out_ready = 1'b0;
      #1;
      n_checks++; if (bus_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %0h want 0", i, bus_if.in_ready); end
      @(negedge clk);
      n_checks++;
      if (bus_if.out_valid !== 1'b1 || bus_if.acc_sum !== 19'h7C000 || bus_if.out_count !== 5'd1 || bus_if.out_forced !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got v=%0h sum=%0h cnt=%0d f=%0h want v=1 sum=7c000 cnt=1 f=0",
                 i, bus_if.out_valid, bus_if.acc_sum, bus_if.out_count, bus_if.out_forced);
      end
    end
    step(1'b0, 15'h0000, 1'b0, 1'b0, 1'b1);
    n_checks++; if (bus_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %0h want 0", bus_if.out_valid); end
  endtask

  task automatic test_forced_close();
    for (int i = 0; i < 16; i++) step(1'b1, 15'h3FFF, 1'b0, 1'b0, 1'b1);
    n_checks++; if (bus_if.acc_sum !== 19'd262128) begin n_fail++; $display("FAIL forced_pos_sum: got %0d want 262128", bus_if.acc_sum); end
    n_checks++; if (bus_if.out_count !== 5'd16) begin n_fail++; $display("FAIL forced_pos_count: got %0d want 16", bus_if.out_count); end
    n_checks++; if (bus_if.out_forced !== 1'b1) begin n_fail++; $display("FAIL forced_pos_flag: got %0h want 1", bus_if.out_forced); end
    for (int i = 0; i < 16; i++) step(1'b1, 15'h4000, 1'b0, 1'b0, 1'b1);
    n_checks++; if (bus_if.acc_sum !== 19'h40000) begin n_fail++; $display("FAIL forced_neg_sum: got %0h want 40000", bus_if.acc_sum); end
    n_checks++; if (bus_if.out_count !== 5'd16 || bus_if.out_forced !== 1'b1) begin n_fail++; $display("FAIL forced_neg_meta: got cnt=%0d f=%0h want cnt=16 f=1", bus_if.out_count, bus_if.out_forced); end
    step(1'b0, 15'h0000, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_flush();
    step(1'b1, 15'h0010, 1'b0, 1'b0, 1'b1);
    step(1'b1, 15'h0020, 1'b0, 1'b0, 1'b1);
    bus_if.in_valid = 1'b1; bus_if.align_pp = 15'h0100; bus_if.in_last = 1'b1;
    bus_if.flush = 1'b1; bus_if.out_ready = 1'b1;
    #1;
    n_checks++; if (bus_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %0h want 0", bus_if.in_ready); end
    @(negedge clk);
    n_checks++; if (bus_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_out: got %0h want 0", bus_if.out_valid); end
    step(1'b1, 15'h0005, 1'b1, 1'b0, 1'b1);
    n_checks++; if (bus_if.acc_sum !== 19'd5 || bus_if.out_count !== 5'd1) begin n_fail++; $display("FAIL flush_result: got sum=%0d cnt=%0d want sum=5 cnt=1", bus_if.acc_sum, bus_if.out_count); end
    step(1'b0, 15'h0000, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 15'(i), 1'b1, 1'b0, 1'b1);
      n_checks++;
      if (bus_if.out_valid !== 1'b1 || bus_if.acc_sum !== 19'(i) || bus_if.out_count !== 5'd1) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got v=%0h sum=%0d cnt=%0d want v=1 sum=%0d cnt=1",
                 i, bus_if.out_valid, bus_if.acc_sum, bus_if.out_count, i);
      end
    end
    // Reset in the middle of a partially accumulated group.
    step(1'b1, 15'h0007, 1'b0, 1'b0, 1'b1);
    step(1'b1, 15'h0008, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    step(1'b1, 15'h0009, 1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    n_checks++; if (bus_if.out_valid !== 1'b0 || bus_if.acc_sum !== 19'd0) begin n_fail++; $display("FAIL rst_mid_group: got v=%0h sum=%0d want v=0 sum=0", bus_if.out_valid, bus_if.acc_sum); end
    step(1'b1, 15'h0004, 1'b1, 1'b0, 1'b0);
    n_checks++; if (bus_if.acc_sum !== 19'd4 || bus_if.out_count !== 5'd1) begin n_fail++; $display("FAIL rst_restart: got sum=%0d cnt=%0d want sum=4 cnt=1", bus_if.acc_sum, bus_if.out_count); end
    // Reset with a result still pending downstream.
    rst = 1'b1;
    step(1'b0, 15'h0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    n_checks++; if (bus_if.out_valid !== 1'b0 || bus_if.acc_sum !== 19'd0 || bus_if.out_count !== 5'd0) begin n_fail++; $display("FAIL rst_pending: got v=%0h sum=%0d cnt=%0d want 0/0/0", bus_if.out_valid, bus_if.acc_sum, bus_if.out_count); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic_group();
    test_backpressure();
    test_forced_close();
    test_flush();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/align_accum.md
ALIGN_ACCUM -- requirements
Module: align_accum

Interface
REQ-001 SHALL have parameter PP_W, default 15, width of a two's-complement aligned partial product from the align stage.
REQ-002 SHALL have parameter MAX_TERMS, default 16, maximum partial products summed per group; power of two, 2..64.
REQ-003 SHALL have derived parameter SUM_W = PP_W + log2(MAX_TERMS), default 19, accumulator/result width.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  align_pp/in_last are valid this cycle.
REQ-007 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-008 SHALL have port align_pp  input  PP_W  signed aligned partial product (sign at MSB).
REQ-009 SHALL have port in_last  input  1  beat is the final term of its group.
REQ-010 SHALL have port flush  input  1  discard the partially accumulated group.
REQ-011 SHALL have port out_valid  output  1  acc_sum/out_count/out_forced are valid.
REQ-012 SHALL have port out_ready  input  1  downstream consumes the result.
REQ-013 SHALL have port acc_sum  output  SUM_W  signed sum of the group.
REQ-014 SHALL have port out_count  output  log2(MAX_TERMS)+1  number of terms in the group.
REQ-015 SHALL have port out_forced  output  1  group closed by MAX_TERMS, not by in_last.

Function
REQ-016 SHALL accept a beat only when in_valid & in_ready; in_ready = ~flush & (~out_valid | out_ready), combinational.
REQ-017 SHALL sign-extend each accepted align_pp to SUM_W before adding; no saturation, no overflow possible by SUM_W sizing.
REQ-018 SHALL keep an internal accumulator acc (SUM_W) and term counter cnt, with states EMPTY (cnt=0) and ACCUM (cnt>0).
REQ-019 SHALL, on an accepted non-closing beat, set acc <= acc + ext(align_pp), cnt <= cnt+1, state ACCUM.
REQ-020 SHALL close a group on an accepted beat with in_last=1 or with cnt = MAX_TERMS-1.
REQ-021 SHALL, on closing, load acc_sum <= acc + ext(align_pp), out_count <= cnt+1, out_forced <= ~in_last, out_valid <= 1, and clear acc, cnt to 0 (state EMPTY), all in the same edge.
REQ-022 SHALL present the result exactly one cycle after the closing beat is accepted (latency 1).
REQ-023 SHALL hold acc_sum, out_count, out_forced stable while out_valid & ~out_ready.
REQ-024 SHALL clear out_valid on out_valid & out_ready unless a new group closes in the same cycle, in which case out_valid stays 1 and the new result loads (full throughput, one group per cycle).
REQ-025 SHALL, when flush=1, clear acc and cnt to 0 (EMPTY); pending output register and out_valid unaffected; in_valid ignored that cycle.
REQ-026 SHALL treat a single beat with in_last=1 in EMPTY as a one-term group (out_count=1).
REQ-027 SHALL treat out_ready while out_valid=0 as don't-care.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, set acc=0, cnt=0, state EMPTY, out_valid=0, acc_sum=0, out_count=0, out_forced=0; rst has priority over flush and any beat, including mid-group and with a pending output (result lost).
REQ-029 SHALL drive in_ready=1 in the first cycle after reset deasserts (with flush=0).

Verification
REQ-030 SHALL cover: rst held 2 cycles -> out_valid=0, acc_sum=0, out_count=0, out_forced=0, in_ready=1.
REQ-031 SHALL cover: beats 15'h3800, 15'h0100, 15'h7F00(last), out_ready=1 -> next cycle out_valid=1, acc_sum=19'd14336, out_count=3, out_forced=0.
REQ-032 SHALL cover: single beat 15'h4000(last) -> acc_sum=19'h7C000 (-16384), out_count=1; then hold out_ready=0 for 5 cycles -> in_ready=0, outputs stable; out_ready=1 -> out_valid drops next cycle.
REQ-033 SHALL cover: 16 beats of 15'h3FFF, in_last=0 -> acc_sum=19'd262128, out_count=16, out_forced=1; then 16 beats of 15'h4000 -> acc_sum=19'h40000 (-262144).
REQ-034 SHALL cover: beats 15'h0010, 15'h0020, then flush=1 with in_valid=1, then 15'h0005(last) -> acc_sum=5, out_count=1.
REQ-035 SHALL cover: back-to-back one-term groups 1,2,3 with out_ready=1 every cycle -> out_valid high 3 consecutive cycles, acc_sum 1,2,3; assert rst mid-group -> result discarded, out_valid=0.
